// File: rtl/freq_scan_sequencer_if.sv
// Signals between the scan sequencer, the control/register block and the measurement datapath.
// The master side is the register block and datapath; the slave side is the sequencer.
interface freq_scan_sequencer_if;
  logic        start;
  logic        abort;
  logic [23:0] chan_mask;
  logic [15:0] samples_cfg;
  logic [7:0]  settle_cfg;
  logic        done_flag;
  logic [9:0]  average;
  logic        irq_ack;
  logic [4:0]  select_input;
  logic        enable;
  logic        meas_nreset;
  logic [15:0] samples_required;
  logic        res_valid;
  logic [4:0]  res_chan;
  logic [9:0]  res_value;
  logic        res_timeout;
  logic        busy;
  logic        irq;

  modport master (
    output start, abort, chan_mask, samples_cfg, settle_cfg, done_flag, average, irq_ack,
    input  select_input, enable, meas_nreset, samples_required, res_valid, res_chan,
           res_value, res_timeout, busy, irq
  );

  modport slave (
    input  start, abort, chan_mask, samples_cfg, settle_cfg, done_flag, average, irq_ack,
    output select_input, enable, meas_nreset, samples_required, res_valid, res_chan,
           res_value, res_timeout, busy, irq
  );
endinterface

// File: rtl/freq_scan_sequencer.sv
// Walks the latched 24-channel mask; for each enabled channel flushes, settles and measures
// the frequency datapath, then writes one result. All outputs come straight from flops.
module freq_scan_sequencer #(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int FLUSH_CYCLES   = 2
) (
  input logic                  Clock,
  input logic                  nReset,
  freq_scan_sequencer_if.slave bus
);

  localparam int TW    = $clog2(TIMEOUT_CYCLES);
  localparam int FW    = $clog2(FLUSH_CYCLES + 1);
  localparam int CW0   = (TW > 8) ? TW : 8;
  localparam int CNT_W = (CW0 > FW) ? CW0 : FW;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, NEXT, FLUSH, SETTLE, MEASURE, STORE, DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       chan_q, chan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      mask_q, mask_d;
  logic [15:0]      samples_q, samples_d;
  logic [7:0]       settle_q, settle_d;
  logic [4:0]       sel_q, sel_d;
  logic             enable_q, enable_d;
  logic             mnrst_q, mnrst_d;
  logic             rvalid_q, rvalid_d;
  logic [4:0]       rchan_q, rchan_d;
  logic [9:0]       rvalue_q, rvalue_d;
  logic             rto_q, rto_d;
  logic             busy_q, busy_d;
  logic             irq_q, irq_d;
  logic             abort_hit;

  assign abort_hit = (state_q != IDLE) && bus.abort;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      chan_q    <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      samples_q <= '0;
      settle_q  <= '0;
      sel_q     <= '0;
      enable_q  <= 1'b0;
      mnrst_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rchan_q   <= '0;
      rvalue_q  <= '0;
      rto_q     <= 1'b0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      samples_q <= samples_d;
      settle_q  <= settle_d;
      sel_q     <= sel_d;
      enable_q  <= enable_d;
      mnrst_q   <= mnrst_d;
      rvalid_q  <= rvalid_d;
      rchan_q   <= rchan_d;
      rvalue_q  <= rvalue_d;
      rto_q     <= rto_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = NEXT;
      NEXT: begin
        if (chan_q == 5'd24)     state_d = DONE;
        else if (mask_q[chan_q]) state_d = FLUSH;
      end
      FLUSH:   if (cnt_q == FL_LAST) state_d = SETTLE;
      SETTLE:  if (cnt_q == CNT_W'(settle_q)) state_d = MEASURE;
      // done_flag and timeout both lead to STORE; the value choice below gives done_flag priority
      MEASURE: if (bus.done_flag || (cnt_q == TO_LAST)) state_d = STORE;
      STORE:   state_d = NEXT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_comb begin
    chan_d    = chan_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    samples_d = samples_q;
    settle_d  = settle_q;
    sel_d     = sel_q;
    rchan_d   = rchan_q;
    rvalue_d  = rvalue_q;
    rto_d     = rto_q;
    irq_d     = irq_q;
    if (bus.irq_ack) irq_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        mask_d    = bus.chan_mask;
        samples_d = bus.samples_cfg;
        settle_d  = bus.settle_cfg;
        chan_d    = '0;
        irq_d     = 1'b0;
      end
      NEXT: if (chan_q != 5'd24) begin
        if (mask_q[chan_q]) begin
          sel_d = chan_q;
          cnt_d = '0;
        end else begin
          chan_d = chan_q + 5'd1;
        end
      end
      FLUSH:   cnt_d = (cnt_q == FL_LAST) ? '0 : cnt_q + CNT_W'(1);
      SETTLE:  cnt_d = (cnt_q == CNT_W'(settle_q)) ? '0 : cnt_q + CNT_W'(1);
      MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d == STORE) begin
          rchan_d  = chan_q;
          rvalue_d = bus.done_flag ? bus.average : 10'h3FF;
          rto_d    = !bus.done_flag;
        end
      end
      STORE:   chan_d = chan_q + 5'd1;
      DONE:    if (!bus.abort) irq_d = 1'b1;
      default: ;
    endcase
    enable_d = (state_d == MEASURE);
    mnrst_d  = (state_d != FLUSH) && !abort_hit;
    rvalid_d = (state_d == STORE);
    busy_d   = (state_d != IDLE);
  end

  assign bus.select_input     = sel_q;
  assign bus.enable           = enable_q;
  assign bus.meas_nreset      = mnrst_q;
  assign bus.samples_required = samples_q;
  assign bus.res_valid        = rvalid_q;
  assign bus.res_chan         = rchan_q;
  assign bus.res_value        = rvalue_q;
  assign bus.res_timeout      = rto_q;
  assign bus.busy             = busy_q;
  assign bus.irq              = irq_q;

endmodule

// File: tb/tb_freq_scan_sequencer.sv
// Bench for freq_scan_sequencer: a datapath responder answers each measurement window after a
// per-channel delay, and a scan-level model predicts results, window lengths and busy time.
module tb_freq_scan_sequencer;
  localparam int TO = 64;
  localparam int FL = 2;

  typedef logic [15:0] res_t;  // {chan[4:0], value[9:0], timeout}

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  freq_scan_sequencer_if bus ();
  freq_scan_sequencer #(.TIMEOUT_CYCLES(TO), .FLUSH_CYCLES(FL)) dut (
    .Clock(clk), .nReset(nrst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int delay_tab [32];
  logic [9:0] avg_tab [32];
  res_t got_q[$];
  res_t exp_q[$];
  int sel_seen[$];
  int exp_sel[$];
  int busy_cnt, en_cnt, nrl_cnt, mcnt;
  int exp_busy, exp_en, exp_nrl;

  // Datapath responder and monitor
  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.enable) en_cnt++;
    if (bus.busy && !bus.meas_nreset) nrl_cnt++;
    if (bus.res_valid) got_q.push_back({bus.res_chan, bus.res_value, bus.res_timeout});
    if (bus.enable) begin
      if (mcnt == 0) sel_seen.push_back(int'(bus.select_input));
      mcnt++;
      if (mcnt == delay_tab[bus.select_input]) begin
        bus.done_flag = 1'b1;
        bus.average   = avg_tab[bus.select_input];
      end else begin
        bus.done_flag = 1'b0;
      end
    end else begin
      mcnt = 0;
      bus.done_flag = 1'b0;
    end
  end

  // A channel answered within TO window cycles yields its average; otherwise a forced 3FF after TO cycles.
  task automatic model(input logic [23:0] mask, input int settle);
    int meas;
    exp_q.delete();
    exp_sel.delete();
    exp_busy = 26;
    exp_en   = 0;
    exp_nrl  = 0;
    for (int c = 0; c < 24; c++) begin
      if (mask[c]) begin
        meas = (delay_tab[c] <= TO) ? delay_tab[c] : TO;
        if (delay_tab[c] <= TO) exp_q.push_back({5'(c), avg_tab[c], 1'b0});
        else                    exp_q.push_back({5'(c), 10'h3FF, 1'b1});
        exp_sel.push_back(c);
        exp_busy += FL + settle + 2 + meas;
        exp_en   += meas;
        exp_nrl  += FL;
      end
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    sel_seen.delete();
    busy_cnt = 0;
    en_cnt   = 0;
    nrl_cnt  = 0;
  endtask

  task automatic run_scan(input string name, input logic [23:0] mask, input logic [7:0] settle,
                          input logic [15:0] samples, input bit poke, input bit ack_at_start,
                          input bit ack_end);
    int n;
    model(mask, int'(settle));
    @(negedge clk);
    clear_obs();
    if (ack_at_start) begin
      checks++;
      if (bus.irq !== 1'b1) begin errors++; $display("FAIL %s_irq_pre: got %0b want 1", name, bus.irq); end
      bus.irq_ack = 1'b1;
    end
    bus.chan_mask   = mask;
    bus.settle_cfg  = settle;
    bus.samples_cfg = samples;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.irq_ack     = 1'b0;
    bus.chan_mask   = ~mask;
    bus.settle_cfg  = settle + 8'd3;
    bus.samples_cfg = ~samples;
    checks++;
    if (bus.samples_required !== samples) begin
      errors++; $display("FAIL %s_samples: got %0h want %0h", name, bus.samples_required, samples);
    end
    if (ack_at_start) begin
      checks++;
      if (bus.irq !== 1'b0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL %s_ack_start: got irq=%0b busy=%0b want irq=0 busy=1", name, bus.irq, bus.busy);
      end
    end
    if (poke) begin
      repeat (15) @(negedge clk);
      bus.chan_mask = 24'hFFFFFF;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
    end
    n = 0;
    while (bus.irq !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL %s_irq_timeout: got irq=%0b want 1", name, bus.irq); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %0b want 0", name, bus.busy); end
    checks++;
    if (busy_cnt != exp_busy) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cnt, exp_busy); end
    checks++;
    if (en_cnt != exp_en) begin errors++; $display("FAIL %s_enable_cycles: got %0d want %0d", name, en_cnt, exp_en); end
    checks++;
    if (nrl_cnt != exp_nrl) begin errors++; $display("FAIL %s_flush_cycles: got %0d want %0d", name, nrl_cnt, exp_nrl); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_result_count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_result%0d: got ch=%0d val=%0h to=%0b want ch=%0d val=%0h to=%0b", name, i,
          got_q[i][15:11], got_q[i][10:1], got_q[i][0], exp_q[i][15:11], exp_q[i][10:1], exp_q[i][0]);
      end
    end
    for (int i = 0; i < exp_sel.size() && i < sel_seen.size(); i++) begin
      checks++;
      if (sel_seen[i] != exp_sel[i]) begin
        errors++; $display("FAIL %s_select%0d: got %0d want %0d", name, i, sel_seen[i], exp_sel[i]);
      end
    end
    if (ack_end) begin
      repeat (3) @(negedge clk);
      checks++;
      if (bus.irq !== 1'b1) begin errors++; $display("FAIL %s_irq_hold: got %0b want 1", name, bus.irq); end
      bus.irq_ack = 1'b1;
      @(negedge clk);
      bus.irq_ack = 1'b0;
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL %s_irq_ack: got %0b want 0", name, bus.irq); end
    end
  endtask

  task automatic check_outputs_reset(input string name);
    checks++;
    if (bus.select_input !== 5'd0 || bus.enable !== 1'b0 || bus.meas_nreset !== 1'b0 ||
        bus.samples_required !== 16'd0 || bus.res_valid !== 1'b0 || bus.res_chan !== 5'd0 ||
        bus.res_value !== 10'd0 || bus.res_timeout !== 1'b0 || bus.busy !== 1'b0 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL %s: got sel=%0d en=%0b mnr=%0b smp=%0h rv=%0b rc=%0d val=%0h to=%0b busy=%0b irq=%0b want all 0",
        name, bus.select_input, bus.enable, bus.meas_nreset, bus.samples_required, bus.res_valid,
        bus.res_chan, bus.res_value, bus.res_timeout, bus.busy, bus.irq);
    end
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_reset("reset_values");
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.meas_nreset !== 1'b1 || bus.busy !== 1'b0 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL reset_release: got mnr=%0b busy=%0b irq=%0b want 1 0 0", bus.meas_nreset, bus.busy, bus.irq);
    end
  endtask

  task automatic test_two_channels();
    for (int c = 0; c < 32; c++) delay_tab[c] = 10;
    avg_tab[0] = 10'd500;
    avg_tab[2] = 10'd731;
    run_scan("two_chan", 24'h000005, 8'd3, 16'd100, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    delay_tab[23] = 1000;
    run_scan("timeout", 24'h800000, 8'd0, 16'd7, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_zero_mask();
    run_scan("zero_mask", 24'h000000, 8'd5, 16'd1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int n;
    for (int c = 0; c < 32; c++) delay_tab[c] = 4;
    avg_tab[0] = 10'd77;
    @(negedge clk);
    clear_obs();
    bus.chan_mask  = 24'hFFFFFF;
    bus.settle_cfg = 8'd6;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.select_input == 5'd1 && bus.meas_nreset && !bus.enable && bus.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin errors++; $display("FAIL abort_reach_settle: got %0d cycles want <500", n); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.meas_nreset !== 1'b0 || bus.enable !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL abort_cycle: got busy=%0b mnr=%0b en=%0b rv=%0b want 0 0 0 0",
        bus.busy, bus.meas_nreset, bus.enable, bus.res_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.meas_nreset !== 1'b1 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL abort_after: got mnr=%0b irq=%0b want 1 0", bus.meas_nreset, bus.irq);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {5'd0, 10'd77, 1'b0}) begin
      errors++; $display("FAIL abort_results: got count=%0d first=%0h want count=1 first=%0h",
        got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hFFFF, {5'd0, 10'd77, 1'b0});
    end
  endtask

  task automatic test_start_while_busy();
    for (int c = 0; c < 32; c++) begin delay_tab[c] = 6; avg_tab[c] = 10'(c * 13 + 1); end
    run_scan("start_busy", 24'h000105, 8'd2, 16'd9, 1'b1, 1'b0, 1'b0);
    run_scan("start_ack", 24'h010020, 8'd1, 16'd11, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_measure();
    int n;
    delay_tab[0] = 200;
    @(negedge clk);
    bus.chan_mask   = 24'h000001;
    bus.settle_cfg  = 8'd1;
    bus.samples_cfg = 16'h1234;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.enable !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.enable !== 1'b1) begin errors++; $display("FAIL rst_mid_reach: got en=%0b want 1", bus.enable); end
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1 check_outputs_reset("rst_mid_measure");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [23:0] mask;
    logic [7:0]  settle;
    int          pick;
    for (int k = 0; k < 4; k++) begin
      mask   = 24'($urandom & $urandom);
      settle = 8'($urandom_range(0, 7));
      for (int c = 0; c < 32; c++) begin
        delay_tab[c] = $urandom_range(1, 80);
        avg_tab[c]   = 10'($urandom);
      end
      pick = $urandom_range(0, 23);
      delay_tab[pick] = 64 + (k % 2);
      mask[pick] = 1'b1;
      run_scan($sformatf("random%0d", k), mask, settle, 16'($urandom), 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.irq_ack = 1'b0;
    bus.chan_mask = '0;
    bus.samples_cfg = '0;
    bus.settle_cfg = '0;
    for (int c = 0; c < 32; c++) begin delay_tab[c] = 5; avg_tab[c] = 10'd0; end
    test_reset();
    test_two_channels();
    test_timeout();
    test_zero_mask();
    test_abort();
    test_start_while_busy();
    test_reset_mid_measure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/freq_scan_sequencer.md
# freq_scan_sequencer

Scan controller for the frequency-counter datapath. It walks a latched mask of the 24 chip-output channels and, for each enabled channel, drives the input-select mux and resets the measurement/averaging datapath. It then opens the measurement window, waits for the averaged result (or a timeout), and emits one result write per channel. The control/register block issues start/abort and receives the results and a completion interrupt.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1048576: maximum MEASURE cycles per channel before the result is forced.
- FLUSH_CYCLES, 2: length of the datapath reset pulse per channel (≥1).

Ports:
- Clock  in  1  system clock, all state on rising edge
- nReset  in  1  asynchronous, active-low reset
- start  in  1  begin scan; sampled only in IDLE
- abort  in  1  terminate scan; valid in any non-IDLE state
- chan_mask  in  24  channel enable bits, latched at start
- samples_cfg  in  16  samples per channel, latched at start
- settle_cfg  in  8  settle cycles after flush, latched at start
- done_flag  in  1  datapath average ready
- average  in  10  datapath averaged frequency
- select_input  out  5  mux channel select
- enable  out  1  measurement enable to counter/buffer
- meas_nreset  out  1  active-low datapath reset
- samples_required  out  16  latched samples_cfg
- res_valid  out  1  one-cycle result write strobe
- res_chan  out  5  channel of current result
- res_value  out  10  result value
- res_timeout  out  1  result was forced by timeout
- busy  out  1  scan in progress
- irq  out  1  scan complete, level, held until irq_ack
- irq_ack  in  1  clears irq

## Operation
- States: IDLE, NEXT, FLUSH, SETTLE, MEASURE, STORE, DONE.
- IDLE: busy=0. On start=1, latch chan_mask, samples_cfg and settle_cfg. Set chan=0, clear irq, go to NEXT.
- NEXT: one channel examined per cycle.
  - chan==24 → DONE.
  - mask[chan]=1 → load select_input=chan and go to FLUSH.
  - Otherwise chan+=1 and stay in NEXT.
- FLUSH: meas_nreset=0 for exactly FLUSH_CYCLES cycles, then SETTLE.
- SETTLE: enable=0, meas_nreset=1. Lasts settle_cfg+1 cycles, then MEASURE.
- MEASURE: enable=1. A timeout counter starts at 0.
  - done_flag=1 → capture average into res_value with res_timeout=0, then STORE.
  - Counter reaches TIMEOUT_CYCLES-1 without done_flag → res_value=10'h3FF, res_timeout=1, then STORE.
  - done_flag and timeout in the same cycle: done_flag wins.
- STORE: enable=0 and res_valid=1 for one cycle, with res_chan=chan. Then chan+=1 and go to NEXT.
- DONE: set irq=1 and go to IDLE. busy is 0 from the IDLE cycle onward.
- abort in any non-IDLE state: next state is IDLE. enable=0, meas_nreset=0 for one cycle, no res_valid, irq unchanged.
- irq_ack clears irq. If irq_ack and start arrive in the same IDLE cycle, both take effect: irq clears and the scan begins.
- start outside IDLE is ignored. Changes to chan_mask/samples_cfg/settle_cfg mid-scan are ignored.
- All-zero mask: 25 NEXT cycles (one per channel plus the chan==24 check), then DONE; irq asserted with zero results.

## Timing
- Reset values: select_input=0, enable=0, meas_nreset=0 while nReset=0 and 1 after release, samples_required=0, res_valid=0, res_chan=0, res_value=0, res_timeout=0, busy=0, irq=0, state IDLE, chan=0.
- busy rises the cycle after start is sampled and falls the cycle after DONE.
- Per-channel overhead outside MEASURE is FLUSH_CYCLES + settle_cfg + 1 + 1 (STORE) + 1 (NEXT) cycles.
- res_valid is asserted in the cycle after done_flag is sampled. res_chan, res_value and res_timeout are stable while res_valid=1 and hold until the next STORE.
- enable falls in the same cycle res_valid rises.
- irq rises one cycle after the final STORE → NEXT(chan==24) → DONE transition.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset mid-MEASURE (nReset low asynchronously): all outputs return to reset values immediately; busy=0, irq=0.
- mask=24'h000005, settle_cfg=3, done_flag 10 cycles into each MEASURE with average=10'd500 then 10'd731: exactly two res_valid pulses, (chan 0, 500) then (chan 2, 731); select_input=2 during the second window; irq=1 afterwards, cleared by irq_ack.
- mask=24'h800000, done_flag never asserted, TIMEOUT_CYCLES=64: one result (chan 23, 10'h3FF, res_timeout=1) with enable high for exactly 64 cycles.
- mask=0: busy high for 26 cycles; no res_valid; irq=1.
- abort during SETTLE of channel 1 with mask=24'hFFFFFF: only the chan 0 result is emitted; state IDLE next cycle; meas_nreset low one cycle; irq stays 0.
- start while busy, and start together with irq_ack: the first is ignored (res_chan sequence unchanged); the second clears irq and starts a new scan in the same cycle.
